// File: rtl/dmem_mmio.sv
// Purpose: M-stage data port: word RAM plus MMIO page (TX byte FIFO, STATUS, CYCLE counter).
// Latency: loads combinational (0 cycles); stores, FIFO pushes and register writes take effect at the next rising edge.
// Backpressure: tx_valid/tx_ready stream; pushes to a full FIFO are dropped and flagged in the sticky ovf bit.
//
// Ports (dmem_mmio):
//   clk, reset        single rising-edge clock; asynchronous active-low reset
//   MemWrite          store strobe for the current M-stage access
//   ALUResult_M       byte address; bit 31 selects MMIO, [1:0] ignored (word accesses only)
//   WriteData_M       store data
//   ReadData          combinational load data for ALUResult_M
//   tx_valid/tx_data  FIFO head byte stream, popped when tx_ready is high

// Purpose: circular byte buffer with occupancy count; head entry read combinationally from storage.
// Latency: a push is visible at the output from the edge that performs it.
// Backpressure: a push while full is refused (caller sees full); a pop while empty is ignored.
module dmem_mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          take;

  // Acceptance uses pre-edge occupancy, so a pop on a full FIFO never makes room for a same-edge push.
  assign accept   = push && !full;
  assign take     = pop && !empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (take)   rd_ptr <= rd_ptr + 1'b1;
      case ({accept, take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_dat;
  end
endmodule

module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic          is_mmio;
  logic [1:0]    sel;
  logic [AW-1:0] ram_idx;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_cycle;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf;
  logic [31:0]   cycle;
  logic [31:0]   status;
  logic          unused_addr;

  // Upper RAM index bits and byte offset are deliberately ignored (RAM aliases).
  assign unused_addr = ^{ALUResult_M[30:AW+2], ALUResult_M[1:0]};

  assign is_mmio   = ALUResult_M[31];
  assign sel       = ALUResult_M[3:2];
  assign ram_idx   = ALUResult_M[AW+1:2];
  assign wr_txdata = MemWrite && is_mmio && (sel == 2'd0);
  assign wr_status = MemWrite && is_mmio && (sel == 2'd1);
  assign wr_cycle  = MemWrite && is_mmio && (sel == 2'd2);

  dmem_mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (wr_txdata),
    .push_dat (WriteData_M[7:0]),
    .pop      (tx_valid && tx_ready),
    .head_dat (tx_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign tx_valid = !fifo_empty;
  assign status   = {16'b0, 8'(fifo_count), 5'b0, ovf, fifo_empty, fifo_full};

  always_ff @(posedge clk) begin
    if (MemWrite && !is_mmio) ram[ram_idx] <= WriteData_M;
  end

  // Set and clear cannot coincide: one store addresses one register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      ovf <= 1'b1;
    end else if (wr_status && WriteData_M[2]) begin
      ovf <= 1'b0;
    end
  end

  // Software load wins over the free-running increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
    end else if (wr_cycle) begin
      cycle <= WriteData_M;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram[ram_idx];
    end else begin
      case (sel)
        2'd1:    ReadData = status;
        2'd2:    ReadData = cycle;
        default: ReadData = '0;
      endcase
    end
  end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Memory-stage data port of the pipelined RISC-V core. It takes the core's M-stage store/address/data signals and returns load data. It contains a word-addressed data RAM and a small memory-mapped I/O page: a transmit byte FIFO with a valid/ready output stream, a status register, and a free-running cycle counter. Loads are combinational so the core can register `ReadData` into its W stage; all state updates happen on the rising clock edge.

## Interface
- `RAM_WORDS`, default 64: data RAM depth in 32-bit words; power of two, at least 4. `AW` = log2(RAM_WORDS).
- `FIFO_DEPTH`, default 8: TX FIFO depth in bytes; power of two, 2–16.
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `MemWrite`  in  1  M-stage store strobe.
- `ALUResult_M`  in  32  M-stage byte address.
- `WriteData_M`  in  32  M-stage store data.
- `ReadData`  out  32  combinational load data for the current `ALUResult_M`.
- `tx_valid`  out  1  FIFO head byte is available.
- `tx_data`  out  8  FIFO head byte.
- `tx_ready`  in  1  downstream consumer accepts the head byte.

## Operation
- **Address decode:** word-granular; `ALUResult_M[1:0]` is ignored and all accesses are full-word.
  - `ALUResult_M[31]`=0: RAM. Index = `ALUResult_M[AW+1:2]`; higher bits are ignored, so the RAM aliases.
  - `ALUResult_M[31]`=1: MMIO. Register select = `ALUResult_M[3:2]`; bits [30:4] are ignored.
- **RAM:**
  - Read is combinational.
  - When `MemWrite`=1, the word is written at the clock edge.
  - RAM contents are not reset; the bench must write before it reads.
- **MMIO sel 0, TXDATA:**
  - A write pushes `WriteData_M[7:0]` into the FIFO.
  - If the FIFO is full at that edge, the byte is dropped and the `ovf` sticky bit is set.
  - Reads return 0.
- **MMIO sel 1, STATUS:** read value is {16'b0, count[7:0], 5'b0, ovf, empty, full}.
  - `count` is the current FIFO occupancy.
  - A write with `WriteData_M[2]`=1 clears `ovf`. All other bits ignore writes.
- **MMIO sel 2, CYCLE:**
  - Reads return the 32-bit counter.
  - A write loads `WriteData_M`; the load has priority over the increment on that edge.
- **MMIO sel 3:** reads 0; writes are ignored.
- **FIFO:**
  - Circular buffer with read/write pointers and an occupancy count.
  - A pop occurs when `tx_valid && tx_ready`.
  - `tx_valid` = (count≠0). `tx_data` = the head entry, combinational from storage.
- **Push/pop rules:**
  - Push acceptance is judged on occupancy before the edge. When full, a simultaneous pop does not admit the push: the byte is dropped, `ovf` is set, and the count decrements.
  - When not full and not empty, a simultaneous push and pop leaves the count unchanged and advances both pointers.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Overflow clear vs set:** `ovf` cannot be both cleared and set in one cycle, because a single store addresses only one register.
- **CYCLE counter:** increments by 1 every cycle when not loaded; wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset (`reset`=0, asynchronous), immediate effect:
  - Pointers = 0, count = 0, `ovf` = 0, CYCLE = 0.
  - `tx_valid`=0. `tx_data` is don't-care; the bench masks it while `tx_valid`=0.
  - `ReadData` stays combinational and follows the address; MMIO reads show the reset values.
- Reset asserted mid-stream discards all queued bytes; the FIFO is empty on release.
- First rising edge after release: CYCLE becomes 1.
- Load latency: 0 cycles. `ReadData` is valid in the same cycle as `ALUResult_M`.
- Store latency: 1 edge. A load to the same address in the next cycle sees the new value.
- TXDATA push to `tx_valid` (empty FIFO): `tx_valid` rises at the edge that performs the push.
- STATUS read in the cycle of a push shows pre-edge values.
- Stream handshake:
  - `tx_data` is stable while `tx_valid`=1 and no pop has occurred.
  - `tx_valid` never drops without a pop, except on reset.
  - `tx_ready` may be high while `tx_valid`=0; this has no effect.

## Test plan
- **Reset values:** assert `reset`=0 mid-run with 3 bytes queued, then release. Required: `tx_valid`=0; STATUS read = 0x0000_0002; CYCLE read at the first cycle after release = 0, and 1 after the next edge.
- **RAM:** store 0xDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 next cycle. Required: 0xDEAD_BEEF. Load 0x0000_0110 with `RAM_WORDS`=64 (alias). Required: 0xDEAD_BEEF.
- **FIFO ordering:** with `tx_ready`=0, push 0x41, 0x42, 0x43; STATUS count = 3. Then raise `tx_ready`. Required: `tx_data` = 0x41, 0x42, 0x43 on three consecutive cycles, then `tx_valid`=0 and STATUS = 0x0000_0002.
- **Overflow:** with `tx_ready`=0, push 9 bytes into the depth-8 FIFO. Required: STATUS = 0x0000_0805. The 9th byte is never emitted. Write STATUS with 0x4. Required: STATUS = 0x0000_0801.
- **Full + simultaneous events:** on a full FIFO, push while `tx_ready`=1. Required: the byte is dropped, `ovf`=1, count = 7. On a half-full FIFO, push and pop in the same cycle. Required: count unchanged and order preserved.
- **CYCLE counter:** write CYCLE = 0xFFFF_FFFE, then read on the following cycles. Required: 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. Read sel 3 and TXDATA. Required: 0.
